renode_outputs: RTL
===================

// Module: renode_outputs
// PURPOSE
//  Receiver side of the Renode GPIO/interrupt message path. Takes interrupt messages
//  from Renode (address = line index, data = level) and drives registered output lines
//  into the HDL design. Buffers commands in a small FIFO and returns one response per command.
//  Sits between the co-simulation connection adapter and the peripheral's GPIO input pins.
// PARAMETERS
//  OutputsCount  1     number of driven output lines (1..64)
//  FifoDepth     4     command FIFO entries (power of two, >=2)
//  ResetValue    '0    OutputsCount-bit value of outputs after reset/clear
//  IrqAction     8'd0  msg_action encoding that denotes an interrupt message
// PORTS
//  clk          in   1             clock; all logic on posedge
//  rst_n        in   1             asynchronous active-low reset
//  clear        in   1             synchronous flush + outputs to ResetValue
//  msg_valid    in   1             command valid
//  msg_ready    out  1             command ready (FIFO not full)
//  msg_action   in   8             message action code
//  msg_address  in   64            output line index
//  msg_data     in   64            level; any nonzero value = 1
//  outputs      out  OutputsCount  registered output lines
//  rsp_valid    out  1             response valid
//  rsp_ready    in   1             response accepted
//  rsp_error    out  1             1 = command rejected, outputs untouched
//  rsp_address  out  64            msg_address of the command being answered
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, state IDLE, outputs=ResetValue, rsp_valid=0,
//   rsp_error=0, rsp_address=0, msg_ready=1 from the first edge after release.
//  clear=1 (sync, wins over everything): same effect as reset; an in-flight response is
//   dropped; msg_ready=0 in a cycle with clear=1 (nothing is accepted).
//  Accept: push when msg_valid&&msg_ready; msg_ready = !full (registered count; no
//   full-bypass). Push and pop in the same cycle: count unchanged.
//  FSM:
//   IDLE:    FIFO non-empty -> pop head into command reg, go to APPLY.
//   APPLY:   1 cycle; valid = action==IrqAction && address<OutputsCount.
//            If valid: outputs[address] <= |data; other bits are held.
//            rsp_valid<=1, rsp_error<=!valid, rsp_address<=address; go to RESPOND.
//   RESPOND: hold rsp_* stable until rsp_valid&&rsp_ready; then rsp_valid<=0, go to IDLE.
//  Latency: command accepted at edge N; popped at edge N+1; outputs and rsp_valid
//   update at edge N+2. Peak throughput is 1 command per 3 cycles with rsp_ready tied high.
//  Ordering: commands are applied and answered strictly in FIFO order. Writing the current
//   level is legal, leaves outputs unchanged, and returns rsp_error=0.
//  Width rules: address compares across full 64 bits (no truncation or wrap);
//   level = OR-reduction of all 64 data bits.
//  Backpressure: if rsp_ready is held low, the FIFO fills; msg_ready drops once
//   count==FifoDepth and rises the cycle after the next pop.
//  Pointers wrap modulo FifoDepth; count is $clog2(FifoDepth)+1 bits wide.
//  Reset/clear mid-APPLY or mid-RESPOND: the command is lost, with no response and no
//   partial output update.
// TESTING
//  1 OutputsCount=4; send (IrqAction,addr=2,data=1) -> outputs=4'b0100 at edge N+2;
//    rsp_error=0, rsp_address=2.
//  2 addr=4 (out of range) and addr=64'h1_0000_0002 -> outputs unchanged, rsp_error=1;
//    action=8'd5 -> rsp_error=1.
//  3 rsp_ready=0, send 6 commands, FifoDepth=4 -> 4 queued plus 1 in the FSM, msg_ready=0;
//    release -> 5 responses in order, 6th accepted after the first pop.
//  4 data=64'h8000_0000_0000_0000 -> line set to 1; data=0 -> line cleared; same level
//    twice -> no change, rsp_error=0.
//  5 rst_n low during RESPOND with 2 queued -> outputs=ResetValue, rsp_valid=0, FIFO empty,
//    no stale response after release.
//  6 clear=1 for 1 cycle while msg_valid=1 -> command not accepted, outputs=ResetValue;
//    the next command works normally.

Source files
------------

// File: rtl/renode_outputs_if.sv
`default_nettype none
// ============================================================================
// Module   : renode_outputs_if
// Brief    : Command/response bundle between the co-simulation adapter and
//            the Renode GPIO output receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface renode_outputs_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_action;
    logic [63:0] msg_address;
    logic [63:0] msg_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_error;
    logic [63:0] rsp_address;

    modport master (
        output msg_valid, msg_action, msg_address, msg_data, rsp_ready,
        input  msg_ready, rsp_valid, rsp_error, rsp_address
    );

    modport slave (
        input  msg_valid, msg_action, msg_address, msg_data, rsp_ready,
        output msg_ready, rsp_valid, rsp_error, rsp_address
    );
endinterface
`default_nettype wire

// File: rtl/renode_outputs.sv
`default_nettype none
// ============================================================================
// Module   : renode_outputs
// Brief    : Receives Renode interrupt messages, queues them, drives registered
//            output lines and answers each command with one response.
// Revision : 1.0 - initial release
// ============================================================================
module renode_outputs #(
    parameter int                      OutputsCount = 1,
    parameter int                      FifoDepth    = 4,
    parameter logic [OutputsCount-1:0] ResetValue   = '0,
    parameter logic [7:0]              IrqAction    = 8'd0
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    clear,
    renode_outputs_if.slave              bus,
    output logic [OutputsCount-1:0]      outputs
);

    localparam int                c_PTR_W = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FifoDepth);
    localparam logic [63:0]       c_LINES = 64'(OutputsCount);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    // Only the reduced level is stored; the 64-bit payload is never needed again.
    logic [7:0]          r_fifo_action  [FifoDepth];
    logic [63:0]         r_fifo_address [FifoDepth];
    logic                r_fifo_level   [FifoDepth];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ready_en;

    state_t              r_state;
    logic [7:0]          r_cmd_action;
    logic [63:0]         r_cmd_address;
    logic                r_cmd_level;
    logic [OutputsCount-1:0] r_outputs;
    logic                r_rsp_valid;
    logic                r_rsp_error;
    logic [63:0]         r_rsp_address;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_cmd_ok;
    logic [OutputsCount-1:0] w_next_outputs;

    assign w_ready  = r_ready_en && !clear && (r_count != c_FULL);
    assign w_push   = bus.msg_valid && w_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && !clear;
    assign w_cmd_ok = (r_cmd_action == IrqAction) && (r_cmd_address < c_LINES);

    // Full 64-bit compare per line, so out-of-range addresses can never alias.
    for (genvar i = 0; i < OutputsCount; i++) begin : g_line
        assign w_next_outputs[i] = (r_cmd_address == 64'(i)) ? r_cmd_level : r_outputs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_action[r_wr_ptr]  <= bus.msg_action;
            r_fifo_address[r_wr_ptr] <= bus.msg_address;
            r_fifo_level[r_wr_ptr]   <= |bus.msg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cmd_action  <= '0;
            r_cmd_address <= '0;
            r_cmd_level   <= 1'b0;
            r_outputs     <= ResetValue;
            r_rsp_valid   <= 1'b0;
            r_rsp_error   <= 1'b0;
            r_rsp_address <= '0;
        end else if (clear) begin
            r_state       <= S_IDLE;
            r_outputs     <= ResetValue;
            r_rsp_valid   <= 1'b0;
            r_rsp_error   <= 1'b0;
            r_rsp_address <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd_action  <= r_fifo_action[r_rd_ptr];
                        r_cmd_address <= r_fifo_address[r_rd_ptr];
                        r_cmd_level   <= r_fifo_level[r_rd_ptr];
                        r_state       <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (w_cmd_ok) begin
                        r_outputs <= w_next_outputs;
                    end
                    r_rsp_valid   <= 1'b1;
                    r_rsp_error   <= !w_cmd_ok;
                    r_rsp_address <= r_cmd_address;
                    r_state       <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.msg_ready   = w_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_address = r_rsp_address;
    assign outputs         = r_outputs;

endmodule
`default_nettype wire
